apple1_dma_arbiter: RTL and testbench

- Shares the Apple-1 system memory bus (16-bit address, 8-bit data, synchronous 1-cycle-read RAM/ROM) between the 6502 core and a host loader/debug port (DMA).
- The block steals bus cycles by pulling the CPU's RDY low, muxes address, write data and write enable, and returns read data to the host.
- It re-presents the CPU's held address for one cycle before releasing RDY, so the CPU's pending read data is valid on resume.
- It sits between cpu_6502, the address decoder/memories and the host interface.

---
 rtl/apple1_dma_arbiter.sv | 124 ++++++++++++
 tb/tb_apple1_dma_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apple1_dma_arbiter.sv
// rtl/apple1_dma_arbiter.sv - Apple-1 bus arbiter: steals CPU cycles via RDY for host DMA accesses.
// Optional stolen-cycle counter built when ARB_STATS_EN is defined.
module apple1_dma_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16,
  parameter int MIN_CPU   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_ab,
  input  logic [DW-1:0] cpu_do,
  input  logic          cpu_we,
  input  logic          rdy_in,
  output logic          cpu_rdy,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
`ifdef ARB_STATS_EN
  input  logic          stats_clr,
  output logic [15:0]   stolen_cycles,
`endif
  output logic          dma_active
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int GW = (MIN_CPU > 0) ? $clog2(MIN_CPU + 1) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(MIN_CPU);

  typedef enum logic [1:0] {IDLE, STALL, GRANT, RESTORE} state_t;

  state_t        state, state_n;
  logic          stall;
  logic          host_sel;
  logic [BW-1:0] burst_cnt;
  logic [GW-1:0] gap_cnt;
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    stall    = 1'b0;
    host_sel = 1'b0;
    host_gnt = 1'b0;
    case (state)
      IDLE: begin
        if (host_req && gap_cnt == '0) state_n = STALL;
      end
      STALL: begin
        stall   = 1'b1;
        state_n = GRANT;
      end
      GRANT: begin
        stall    = 1'b1;
        host_sel = 1'b1;
        host_gnt = host_req;
        // Release on an idle grant cycle or once this access fills the burst
        if (!host_req || burst_cnt == BURST_LAST) state_n = RESTORE;
      end
      RESTORE: begin
        stall   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign cpu_rdy    = rdy_in & ~stall;
  assign dma_active = (state != IDLE);
  assign mem_addr   = host_sel ? host_addr  : cpu_ab;
  assign mem_wdata  = host_sel ? host_wdata : cpu_do;
  assign mem_we     = host_sel ? (host_req & host_we) : cpu_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      if (state == RESTORE)  burst_cnt <= '0;
      else if (host_gnt)     burst_cnt <= burst_cnt + 1'b1;
      if (state == RESTORE)                    gap_cnt <= GAP_LOAD;
      else if (state == IDLE && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // Memory returns data the cycle after the address; hold it once rvalid drops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_rvalid <= 1'b0;
      rdata_q     <= '0;
    end else begin
      host_rvalid <= host_gnt & ~host_we;
      if (host_rvalid) rdata_q <= mem_rdata;
    end
  end

  assign host_rdata = host_rvalid ? mem_rdata : rdata_q;

`ifdef ARB_STATS_EN
  logic [15:0] stolen_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             stolen_q <= '0;
    else if (stats_clr)                    stolen_q <= '0;
    else if (stall && stolen_q != 16'hFFFF) stolen_q <= stolen_q + 16'd1;
  end

  assign stolen_cycles = stolen_q;
`endif

endmodule

// File: tb/tb_apple1_dma_arbiter.sv
// tb/tb_apple1_dma_arbiter.sv - self-checking bench for apple1_dma_arbiter with a window-based reference model.
module tb_apple1_dma_arbiter;
  localparam int MAXB = 16;
  localparam int MINC = 4;

  logic        clk, reset;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic        cpu_we, rdy_in, cpu_rdy;
  logic        host_req, host_we, host_gnt, host_rvalid;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata, host_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, dma_active;
`ifdef ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] stolen_cycles;
`endif

  apple1_dma_arbiter #(.AW(16), .DW(8), .MAX_BURST(MAXB), .MIN_CPU(MINC)) dut (
    .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
    .rdy_in(rdy_in), .cpu_rdy(cpu_rdy), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
`ifdef ARB_STATS_EN
    .stats_clr(stats_clr), .stolen_cycles(stolen_cycles),
`endif
    .dma_active(dma_active));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0, total_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
  endtask

  // Synchronous 1-cycle-read RAM plus the model's own view of its contents
  logic [7:0] ram    [0:65535];
  logic [7:0] shadow [0:65535];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Model: a steal window is one settle cycle, host cycles, one restore cycle
  int   m_win;     // -1 = CPU owns bus, else cycles since the window opened
  bit   m_end;     // window is in its restore cycle
  int   m_taken, m_gap;
  bit   m_rv;
  logic [7:0] m_rdexp;
  int   m_stolen;
  bit   e_host, e_gnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_win = -1; m_end = 0; m_taken = 0; m_gap = 0; m_rv = 0; m_rdexp = 8'h00; m_stolen = 0;
    end else begin
      e_host = (m_win >= 1) && !m_end;
      e_gnt  = e_host && host_req;
`ifdef ARB_STATS_EN
      if (stats_clr) m_stolen = 0;
      else if (m_win >= 0 && m_stolen < 65535) m_stolen = m_stolen + 1;
`endif
      m_rv = e_gnt && !host_we;
      if (m_rv) m_rdexp = shadow[host_addr];
      if (e_host ? (host_req && host_we) : cpu_we)
        shadow[e_host ? host_addr : cpu_ab] = e_host ? host_wdata : cpu_do;
      if (m_win < 0) begin
        if (host_req && m_gap == 0) m_win = 0;
        else if (m_gap > 0) m_gap = m_gap - 1;
      end else if (m_end) begin
        m_win = -1; m_end = 0; m_taken = 0; m_gap = MINC;
      end else if (m_win == 0) begin
        m_win = 1;
      end else begin
        if (host_req) m_taken = m_taken + 1;
        if (!host_req || m_taken == MAXB) m_end = 1;
        m_win = m_win + 1;
      end
    end
  end

  // Per-cycle compare plus scenario counters
  int   rdy_low, we0300, gnt_cnt, win_cnt, run, last_run;
  bit   prev_rdy = 1, prev_dma = 0;
  logic [7:0] resume_byte;
  logic [7:0] rq[$];
  bit   c_host;

  always @(negedge clk) begin
    c_host = (m_win >= 1) && !m_end;
    chk("cpu_rdy", cpu_rdy, rdy_in && !(m_win >= 0));
    chk("host_gnt", host_gnt, c_host && host_req);
    chk("dma_active", dma_active, m_win >= 0);
    chk("mem_bus", {mem_addr, mem_wdata, mem_we},
        c_host ? {host_addr, host_wdata, host_req & host_we} : {cpu_ab, cpu_do, cpu_we});
    chk("host_rvalid", host_rvalid, m_rv);
    if (m_rv) chk("host_rdata", host_rdata, m_rdexp);
`ifdef ARB_STATS_EN
    chk("stolen_cycles", stolen_cycles, m_stolen);
`endif
    if (!cpu_rdy) rdy_low++;
    if (mem_we && mem_addr == 16'h0300) we0300++;
    if (host_gnt) gnt_cnt++;
    if (host_rvalid) rq.push_back(host_rdata);
    if (dma_active && !prev_dma) win_cnt++;
    if (cpu_rdy && !prev_rdy) resume_byte = mem_rdata;
    if (cpu_rdy) run++;
    else begin
      if (run > 0) last_run = run;
      run = 0;
    end
    prev_rdy = cpu_rdy;
    prev_dma = dma_active;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_counts();
    rdy_low = 0; we0300 = 0; gnt_cnt = 0; rq.delete();
  endtask

  // Host holds req and advances its address after each grant
  task automatic host_burst(input bit we, input logic [15:0] a, input logic [7:0] d, input int n);
    int got = 0;
    int t = 0;
    host_req = 1; host_we = we; host_addr = a; host_wdata = d;
    while (got < n && t < 300) begin
      if (host_gnt) got++;
      cyc(1);
      t++;
      if (got < n) host_addr = a + 16'(got);
      else host_req = 0;
    end
    host_req = 0;
    chk("burst_done", got, n);
  endtask

  int t;
  int w0;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 8'h00;
      shadow[i] = 8'h00;
    end
    ram[16'hFF00] = 8'hD8; ram[16'hFF01] = 8'h58; ram[16'hFF02] = 8'hA0; ram[16'hFF03] = 8'h7F;
    shadow[16'hFF00] = 8'hD8; shadow[16'hFF01] = 8'h58; shadow[16'hFF02] = 8'hA0; shadow[16'hFF03] = 8'h7F;
    reset = 1; rdy_in = 1; cpu_ab = 16'h1234; cpu_do = 8'h00; cpu_we = 0;
    host_req = 0; host_we = 0; host_addr = 16'h0000; host_wdata = 8'h00;
    run = 0; last_run = 0; win_cnt = 0; resume_byte = 8'h00;
    clr_counts();
`ifdef ARB_STATS_EN
    stats_clr = 0;
`endif
    cyc(2);
    chk("rst_cpu_rdy", cpu_rdy, 1'b1);
    chk("rst_gnt", host_gnt, 1'b0);
    chk("rst_rvalid", host_rvalid, 1'b0);
    chk("rst_rdata", host_rdata, 8'h00);
    chk("rst_dma", dma_active, 1'b0);
    reset = 0;
    cyc(3);

    // Single write: STALL, GRANT(access), GRANT(req low), RESTORE
    clr_counts();
    host_burst(1, 16'h0300, 8'hA5, 1);
    cyc(8);
    chk("wr_rdy_low", rdy_low, 4);
    chk("wr_we0300", we0300, 1);
    chk("wr_ram", ram[16'h0300], 8'hA5);
    chk("wr_cpu_ab", mem_addr, 16'h1234);

    // Read burst of 4 from the monitor ROM area; CPU waits on FF02
    cpu_ab = 16'hFF02;
    cyc(8);
    clr_counts();
    host_burst(0, 16'hFF00, 8'h00, 4);
    cyc(8);
    chk("rd_gnts", gnt_cnt, 4);
    chk("rd_rdy_low", rdy_low, 7);
    chk("rd_count", rq.size(), 4);
    if (rq.size() == 4) begin
      chk("rd_b0", rq[0], 8'hD8);
      chk("rd_b1", rq[1], 8'h58);
      chk("rd_b2", rq[2], 8'hA0);
      chk("rd_b3", rq[3], 8'h7F);
    end
    chk("cpu_resume_byte", resume_byte, 8'hA0);

    // Long request: forced release every MAXB accesses with a CPU gap between windows
    cpu_ab = 16'h1234;
    cyc(8);
    clr_counts();
    w0 = win_cnt;
    host_burst(1, 16'h2000, 8'h5A, 40);
    cyc(10);
    chk("max_gnts", gnt_cnt, 40);
    chk("max_windows", win_cnt - w0, 3);
    chk("max_gap_run", last_run, 5);
    chk("max_rdy_low", rdy_low, 47);
    chk("max_ram_last", ram[16'h2027], 8'h5A);

    // Async reset during the second grant cycle of a read burst
    cpu_ab = 16'hFF00;
    cyc(8);
    clr_counts();
    host_req = 1; host_we = 0; host_addr = 16'hFF01;
    t = 0;
    while (!host_gnt && t < 20) begin
      cyc(1);
      t++;
    end
    chk("arst_first_gnt", host_gnt, 1'b1);
    cyc(1);
    #2 reset = 1;
    #1;
    chk("arst_cpu_rdy", cpu_rdy, rdy_in);
    chk("arst_gnt", host_gnt, 1'b0);
    chk("arst_dma", dma_active, 1'b0);
    host_req = 0;
    cyc(1);
    chk("arst_rvalid", host_rvalid, 1'b0);
    reset = 0;
    cyc(3);
    chk("arst_no_rdata", rq.size(), 0);

    // External RDY low does not block arbitration and persists afterwards
    cpu_ab = 16'h1234;
    cyc(8);
    rdy_in = 0;
    w0 = win_cnt;
    host_burst(1, 16'h0400, 8'h3C, 1);
    cyc(4);
    chk("rdyin_window", win_cnt - w0, 1);
    chk("rdyin_hold", cpu_rdy, 1'b0);
    chk("rdyin_ram", ram[16'h0400], 8'h3C);
    rdy_in = 1;
    #1;
    chk("rdyin_release", cpu_rdy, 1'b1);
    cyc(8);

`ifdef ARB_STATS_EN
    stats_clr = 1;
    cyc(1);
    stats_clr = 0;
    host_burst(1, 16'h0500, 8'h11, 1);
    cyc(8);
    host_burst(1, 16'h0501, 8'h22, 1);
    cyc(8);
    chk("stats_two", stolen_cycles, 16'd8);
    stats_clr = 1;
    cyc(1);
    stats_clr = 0;
    #1;
    chk("stats_clr", stolen_cycles, 16'd0);
    force dut.stolen_q = 16'hFFFE;
    m_stolen = 16'hFFFE;
    #1 release dut.stolen_q;
    cyc(1);
    host_burst(1, 16'h0502, 8'h33, 1);
    cyc(8);
    chk("stats_sat", stolen_cycles, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
